// File: rtl/brlite_local_arbiter_if.sv
// BrLite local-port injection arbiter: flit types and requester/router bundle.
// The slave modport is the arbiter's view; master is the environment's view.
package brlite_pkg;
  typedef logic [3:0] br_id_t;
  typedef struct packed {
    logic [1:0] service;
    logic [7:0] seq_source;
    br_id_t     id;
    logic [7:0] payload;
  } br_data_t;
endpackage

interface brlite_local_arbiter_if #(
  parameter int NREQ = 4
);
  import brlite_pkg::*;
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]      req_i;
  br_data_t [NREQ-1:0]  flit_i;
  logic [NREQ-1:0]      ack_o;
  br_data_t             rtr_flit_o;
  logic                 rtr_req_o;
  logic                 rtr_ack_i;
  logic                 rtr_busy_i;
  logic [IW-1:0]        grant_idx_o;

  modport slave (
    input  req_i, flit_i, rtr_ack_i, rtr_busy_i,
    output ack_o, rtr_flit_o, rtr_req_o, grant_idx_o
  );

  modport master (
    output req_i, flit_i, rtr_ack_i, rtr_busy_i,
    input  ack_o, rtr_flit_o, rtr_req_o, grant_idx_o
  );
endinterface

// File: rtl/brlite_local_arbiter.sv
// Round-robin arbiter sharing one BrLite LOCAL port among NREQ requesters.
// Optional BRLITE_INJ_ID_EN stamps an internal wrapping id on each injection.
module brlite_local_arbiter
  import brlite_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  brlite_local_arbiter_if.slave  bus
);
  localparam int IW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  br_data_t        flit_q, flit_d;
  logic            req_q, req_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   k;
  logic            sel_vld;

`ifdef BRLITE_INJ_ID_EN
  br_id_t id_q, id_d;
`endif

  // Scan downward so the smallest offset from last+1 wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = last_q;
    k       = '0;
    for (int i = NREQ; i >= 1; i--) begin
      k = IW'((int'(last_q) + i) % NREQ);
      if (bus.req_i[k]) begin
        sel_vld = 1'b1;
        sel_idx = k;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gidx_d  = gidx_q;
    flit_d  = flit_q;
    req_d   = req_q;
    ack_d   = '0;
`ifdef BRLITE_INJ_ID_EN
    id_d    = id_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (sel_vld && !bus.rtr_busy_i) begin
          flit_d  = bus.flit_i[sel_idx];
`ifdef BRLITE_INJ_ID_EN
          flit_d.id = id_q;
`endif
          req_d   = 1'b1;
          gidx_d  = sel_idx;
          last_d  = sel_idx;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.rtr_ack_i) begin
          req_d         = 1'b0;
          ack_d[gidx_q] = 1'b1;
          state_d       = S_HOLD;
`ifdef BRLITE_INJ_ID_EN
          id_d          = id_q + 1'b1;
`endif
        end
      end
      S_HOLD: begin
        if (!bus.rtr_busy_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      last_q  <= IW'(NREQ - 1);
      gidx_q  <= '0;
      flit_q  <= '0;
      req_q   <= 1'b0;
      ack_q   <= '0;
`ifdef BRLITE_INJ_ID_EN
      id_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      flit_q  <= flit_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
`ifdef BRLITE_INJ_ID_EN
      id_q    <= id_d;
`endif
    end
  end

  assign bus.ack_o       = ack_q;
  assign bus.rtr_flit_o  = flit_q;
  assign bus.rtr_req_o   = req_q;
  assign bus.grant_idx_o = gidx_q;
endmodule

// File: tb/tb_brlite_local_arbiter.sv
// Scoreboard bench for brlite_local_arbiter with a simple router model.
// Expected id follows BRLITE_INJ_ID_EN the same way the design build does.
module tb_brlite_local_arbiter;
  import brlite_pkg::*;
  localparam int NREQ = 4;

  typedef struct {
    int         idx;
    logic [7:0] pl;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic [7:0] pl_tab [NREQ] = '{8'hA5, 8'hB1, 8'hC2, 8'hD3};
  br_id_t id_cnt;
  int   w;

  always #5 clk = ~clk;

  brlite_local_arbiter_if #(.NREQ(NREQ)) bus ();

  brlite_local_arbiter #(.NREQ(NREQ)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int idx);
    exp_t e;
    e.idx = idx;
    e.pl  = pl_tab[idx];
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    bus.req_i      = '0;
    bus.rtr_ack_i  = 1'b0;
    bus.rtr_busy_i = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    id_cnt = '0;
    sb.delete();
  endtask

  task automatic inject(input logic [NREQ-1:0] mid_req,
                        input logic [NREQ-1:0] next_req,
                        input int ack_dly, input int busy_cyc,
                        output int waited);
    exp_t     e;
    br_data_t cap;
    br_id_t   eid;
    int       bad;
    waited = 0;
    while (!bus.rtr_req_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("req_seen", 32'(bus.rtr_req_o), 32'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
`ifdef BRLITE_INJ_ID_EN
    eid = id_cnt;
`else
    eid = 4'd7;
`endif
    cap = bus.rtr_flit_o;
    chk("grant_idx", 32'(bus.grant_idx_o), 32'(e.idx));
    chk("payload", 32'(cap.payload), 32'(e.pl));
    chk("flit_id", 32'(cap.id), 32'(eid));
    bus.req_i = mid_req;
    repeat (ack_dly) @(negedge clk);
    chk("req_hold", 32'(bus.rtr_req_o), 32'd1);
    chk("flit_hold", 32'(bus.rtr_flit_o), 32'(cap));
    bus.rtr_ack_i  = 1'b1;
    bus.rtr_busy_i = (busy_cyc > 0);
    @(negedge clk);
    bus.rtr_ack_i = 1'b0;
    id_cnt++;
    chk("req_drop", 32'(bus.rtr_req_o), 32'd0);
    chk("ack_pulse", 32'(bus.ack_o), 32'(4'b0001 << e.idx));
    bus.req_i = next_req;
    @(negedge clk);
    chk("ack_one", 32'(bus.ack_o), 32'd0);
    if (busy_cyc > 0) begin
      bad = 0;
      repeat (busy_cyc - 1) begin
        @(negedge clk);
        if (bus.rtr_req_o) bad++;
      end
      chk("busy_hold", 32'(bad), 32'd0);
      bus.rtr_busy_i = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    id_cnt = '0;
    bus.req_i      = '0;
    bus.rtr_ack_i  = 1'b0;
    bus.rtr_busy_i = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      bus.flit_i[i].service    = 2'd0;
      bus.flit_i[i].seq_source = 8'(i);
      bus.flit_i[i].id         = 4'd7;
      bus.flit_i[i].payload    = pl_tab[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(bus.rtr_req_o), 32'd0);
    chk("rst_ack", 32'(bus.ack_o), 32'd0);
    chk("rst_flit", 32'(bus.rtr_flit_o), 32'd0);
    chk("rst_gidx", 32'(bus.grant_idx_o), 32'd0);
    rst = 1'b0;

    // Single requester, router acks after 3 cycles
    bus.req_i = 4'b0001;
    push_exp(0);
    inject(4'b0001, 4'b0000, 3, 0, w);

    // Ack outside SEND is ignored
    @(negedge clk);
    bus.rtr_ack_i = 1'b1;
    @(negedge clk);
    bus.rtr_ack_i = 1'b0;
    chk("stray_ack", 32'(bus.ack_o), 32'd0);
    chk("stray_req", 32'(bus.rtr_req_o), 32'd0);

    // Fairness with all four requesting
    do_reset();
    bus.req_i = 4'b1111;
    for (int r = 0; r < 8; r++) push_exp(r % NREQ);
    for (int r = 0; r < 8; r++)
      inject(4'b1111, (r == 7) ? 4'b0000 : 4'b1111, 0, 0, w);

    // Busy holdoff
    do_reset();
    bus.req_i = 4'b0001;
    push_exp(0);
    inject(4'b0001, 4'b0010, 1, 50, w);
    push_exp(1);
    inject(4'b0010, 4'b0000, 1, 0, w);
    chk("busy_lat", 32'(w <= 2), 32'd1);

    // Requester 2 withdraws after grant; 3 is next
    do_reset();
    bus.req_i = 4'b1100;
    push_exp(2);
    inject(4'b1000, 4'b1000, 2, 0, w);
    push_exp(3);
    inject(4'b1000, 4'b0000, 1, 0, w);

    // Reset mid-SEND
    do_reset();
    bus.req_i = 4'b0011;
    push_exp(0);
    inject(4'b0011, 4'b0011, 0, 0, w);
    w = 0;
    while (!bus.rtr_req_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("mid_gidx", 32'(bus.grant_idx_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_req", 32'(bus.rtr_req_o), 32'd0);
    chk("mrst_ack", 32'(bus.ack_o), 32'd0);
    chk("mrst_gidx", 32'(bus.grant_idx_o), 32'd0);
    rst    = 1'b0;
    id_cnt = '0;
    sb.delete();
    push_exp(0);
    inject(4'b0011, 4'b0000, 1, 0, w);
    chk("mrst_lat", 32'(w), 32'd1);

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
